// File: rtl/debug_mem_reader.sv
// debug_mem_reader: reader end of the debug address sweep.
// Walks a synchronous debug RAM (1-cycle read latency) from address 0 to
// LENGTH-1 and streams {addr, data, last} through a small output FIFO.
// Read issue is credit-gated, so a returning word always has a FIFO slot.
// Optional feature macro: DEBUG_MEM_READER_CHKSUM_EN adds a running XOR
// checksum output of all words handshaken in the current sweep.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// ISSUE | issuing reads 0..LENGTH-1 as credit allows
// DRAIN | all reads issued; waiting for the last word to handshake
module debug_mem_reader #(
  parameter int LENGTH     = 12000,
  parameter int WIDTH      = $clog2(LENGTH),
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_re,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_addr,
  output logic [DW-1:0]    m_data,
  output logic             m_last
`ifdef DEBUG_MEM_READER_CHKSUM_EN
  ,
  output logic [DW-1:0]    chksum
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 2;
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(LENGTH - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  logic             inflight;
  logic [WIDTH-1:0] addr_d;

  logic [WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0]    fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [CW-1:0]    credit;
  logic [CW-1:0]    credit_next;
  logic             push;
  logic             pop;
  logic             push_last;

  // The word returning this cycle belongs to the read issued last cycle.
  assign push      = inflight;
  assign push_last = (addr_d == LAST_ADDR);

  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  assign m_addr  = fifo_addr[rd_ptr];
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];

  // Credit now, and the credit the next cycle will see: the read issued now
  // consumes a slot, a pop now frees one. mem_re is registered from the latter.
  always_comb begin
    credit      = DEPTH_C - count - CW'(inflight);
    credit_next = credit - CW'(mem_re) + CW'(pop);
  end

  // Sweep sequencer: state, read issue and address walk, busy/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_addr <= '0;
            mem_re   <= (credit_next != '0);
          end
        end
        ISSUE: begin
          if (mem_re && (mem_addr == LAST_ADDR)) begin
            // Final read going out now; hold the address, stop issuing.
            state  <= DRAIN;
            mem_re <= 1'b0;
          end else begin
            if (mem_re) begin
              mem_addr <= mem_addr + WIDTH'(1);
            end
            mem_re <= (credit_next != '0);
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

  // Return path: remember which address the outstanding read targets.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
      addr_d   <= '0;
    end else begin
      inflight <= mem_re;
      if (mem_re) begin
        addr_d <= mem_addr;
      end
    end
  end

  // Output FIFO; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= addr_d;
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DEBUG_MEM_READER_CHKSUM_EN
  // Running XOR of handshaken words; restarts on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chksum <= '0;
    end else if ((state == IDLE) && start) begin
      chksum <= '0;
    end else if (pop) begin
      chksum <= chksum ^ m_data;
    end
  end
`endif

endmodule

// File: tb/tb_debug_mem_reader.sv
// Directed bench for debug_mem_reader: an 8-word instance for the detailed
// scenarios, a 12000-word instance for the full sweep, and a 4-word
// instance for the checksum option when DEBUG_MEM_READER_CHKSUM_EN is set.
module tb_debug_mem_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   total = 0;
  int   bad   = 0;

  // 8-word instance
  logic        start8, busy8, done8, mem_re8, m_valid8, m_ready8, m_last8;
  logic [2:0]  mem_addr8, m_addr8;
  logic [31:0] mem_rdata8, m_data8;

  // 12000-word instance
  logic        start_b, busy_b, done_b, mem_re_b, m_valid_b, m_ready_b, m_last_b;
  logic [13:0] mem_addr_b, m_addr_b;
  logic [31:0] mem_rdata_b, m_data_b;

  debug_mem_reader #(.LENGTH(8), .DW(32), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rstn(rstn), .start(start8), .busy(busy8), .done(done8),
    .mem_re(mem_re8), .mem_addr(mem_addr8), .mem_rdata(mem_rdata8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_addr(m_addr8),
    .m_data(m_data8), .m_last(m_last8)
`ifdef DEBUG_MEM_READER_CHKSUM_EN
    , .chksum()
`endif
  );

  debug_mem_reader #(.LENGTH(12000), .DW(32), .FIFO_DEPTH(4)) ubig (
    .clk(clk), .rstn(rstn), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_addr(m_addr_b),
    .m_data(m_data_b), .m_last(m_last_b)
`ifdef DEBUG_MEM_READER_CHKSUM_EN
    , .chksum()
`endif
  );

  function automatic logic [31:0] big_pat(input logic [13:0] a);
    return ({18'd0, a} * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // RAM models: 1-cycle synchronous read
  always @(posedge clk) if (mem_re8) mem_rdata8 <= {29'd0, mem_addr8} * 32'd3;
  always @(posedge clk) if (mem_re_b) mem_rdata_b <= big_pat(mem_addr_b);

`ifdef DEBUG_MEM_READER_CHKSUM_EN
  logic        start4, busy4, done4, mem_re4, m_valid4, m_ready4, m_last4;
  logic [1:0]  mem_addr4, m_addr4;
  logic [31:0] mem_rdata4, m_data4, chksum4;

  debug_mem_reader #(.LENGTH(4), .DW(32), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rstn(rstn), .start(start4), .busy(busy4), .done(done4),
    .mem_re(mem_re4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_addr(m_addr4),
    .m_data(m_data4), .m_last(m_last4), .chksum(chksum4)
  );

  always @(posedge clk) if (mem_re4) mem_rdata4 <= 32'd1 << mem_addr4;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({busy8, done8, mem_re8, m_valid8, m_last8} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy8, done8, mem_re8, m_valid8, m_last8});
    end
    total++;
    if ({mem_addr8, m_addr8, m_data8} !== 38'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr8, m_addr8, m_data8});
    end
    total++;
    if ({busy_b, done_b, mem_re_b, m_valid_b, mem_addr_b, m_addr_b, m_data_b} !== 64'd0) begin
      bad++;
      $display("FAIL reset_big got=%h exp=0",
               {busy_b, done_b, mem_re_b, m_valid_b, mem_addr_b, m_addr_b, m_data_b});
    end
  endtask

  task automatic test_basic();
    int n;
    m_ready8 = 1'b1;
    start8   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) start8 = 1'b0;
    end while (!m_valid8 && n < 10);
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=3", n);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({m_valid8, m_addr8, m_data8, m_last8} !== {1'b1, 3'(i), 32'(3 * i), (i == 7)}) begin
        bad++;
        $display("FAIL basic_word%0d got v=%b a=%0d d=%0d l=%b exp v=1 a=%0d d=%0d l=%b",
                 i, m_valid8, m_addr8, m_data8, m_last8, i, 3 * i, (i == 7));
      end
      tick();
    end
    total++;
    if ({done8, busy8} !== 2'b10) begin
      bad++;
      $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done8, busy8);
    end
    tick();
    total++;
    if ({done8, busy8, m_valid8} !== 3'b000) begin
      bad++;
      $display("FAIL basic_after_done got=%b exp=000", {done8, busy8, m_valid8});
    end
  endtask

  task automatic test_backpressure();
    int exp_a, dones;
    exp_a = 0;
    dones = 0;
    m_ready8 = 1'b0;
    start8   = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (n == 1) start8 = 1'b0;
      if (done8) begin
        dones++;
        break;
      end
      if (n <= 6)       m_ready8 = n[0];
      else if (n <= 26) m_ready8 = 1'b0;
      else              m_ready8 = 1'b1;
      if (n >= 15 && n <= 26) begin
        total++;
        if ({mem_re8, mem_addr8, m_valid8, m_addr8, m_data8} !== {1'b0, 3'd6, 1'b1, 3'd2, 32'd6}) begin
          bad++;
          $display("FAIL bp_stall n=%0d got re=%b ma=%0d v=%b a=%0d d=%0d exp re=0 ma=6 v=1 a=2 d=6",
                   n, mem_re8, mem_addr8, m_valid8, m_addr8, m_data8);
        end
      end
      if (m_valid8 && m_ready8) begin
        total++;
        if ({m_addr8, m_data8} !== {3'(exp_a), 32'(3 * exp_a)}) begin
          bad++;
          $display("FAIL bp_word got a=%0d d=%0d exp a=%0d d=%0d", m_addr8, m_data8, exp_a, 3 * exp_a);
        end
        exp_a++;
      end
    end
    total++;
    if (exp_a !== 8) begin
      bad++;
      $display("FAIL bp_count got=%0d exp=8", exp_a);
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL bp_done got=%0d exp=1", dones);
    end
  endtask

  task automatic test_start_ignored();
    int exp_a, dones;
    exp_a = 0;
    dones = 0;
    m_ready8 = 1'b1;
    start8   = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      start8 = 1'b0;
      if (done8) dones++;
      if (m_valid8) begin
        total++;
        if ({m_addr8, m_data8} !== {3'(exp_a), 32'(3 * exp_a)}) begin
          bad++;
          $display("FAIL ign_word got a=%0d d=%0d exp a=%0d d=%0d", m_addr8, m_data8, exp_a, 3 * exp_a);
        end
        if (m_addr8 == 3'd3) start8 = 1'b1;
        exp_a++;
      end
    end
    total++;
    if (exp_a !== 8) begin
      bad++;
      $display("FAIL ign_count got=%0d exp=8", exp_a);
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ign_done got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    m_ready8 = 1'b0;
    start8   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) start8 = 1'b0;
    end while (!m_valid8 && n < 10);
    tick();
    total++;
    if ({m_valid8, m_addr8, busy8} !== {1'b1, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_pre got v=%b a=%0d busy=%b exp v=1 a=0 busy=1", m_valid8, m_addr8, busy8);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({busy8, done8, mem_re8, m_valid8, m_last8, mem_addr8, m_addr8, m_data8} !== 43'd0) begin
      bad++;
      $display("FAIL rst_mid got=%h exp=0",
               {busy8, done8, mem_re8, m_valid8, m_last8, mem_addr8, m_addr8, m_data8});
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    total++;
    if ({done8, busy8, m_valid8} !== 3'b000) begin
      bad++;
      $display("FAIL rst_release got=%b exp=000", {done8, busy8, m_valid8});
    end
    m_ready8 = 1'b1;
    start8   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) start8 = 1'b0;
    end while (!m_valid8 && n < 10);
    total++;
    if ({n == 3, m_addr8, m_data8} !== {1'b1, 3'd0, 32'd0}) begin
      bad++;
      $display("FAIL rst_fresh got n=%0d a=%0d d=%0d exp n=3 a=0 d=0", n, m_addr8, m_data8);
    end
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL rst_fresh_done got=%0d exp=8", n);
    end
  endtask

  task automatic test_back_to_back();
    int exp_a, dones;
    m_ready8 = 1'b1;
    start8   = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) start8 = 1'b0;
      if (done8) break;
    end
    total++;
    if (done8 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done got=%b exp=1", done8);
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    total++;
    if ({busy8, mem_re8, mem_addr8} !== {1'b1, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b re=%b ma=%0d exp busy=1 re=1 ma=0", busy8, mem_re8, mem_addr8);
    end
    exp_a = 0;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin
        dones++;
        break;
      end
      if (m_valid8) begin
        total++;
        if ({m_addr8, m_data8, m_last8} !== {3'(exp_a), 32'(3 * exp_a), (exp_a == 7)}) begin
          bad++;
          $display("FAIL b2b_word got a=%0d d=%0d l=%b exp a=%0d d=%0d", m_addr8, m_data8, m_last8, exp_a, 3 * exp_a);
        end
        exp_a++;
      end
      tick();
    end
    total++;
    if ({exp_a == 8, dones == 1} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_second got words=%0d dones=%0d exp words=8 dones=1", exp_a, dones);
    end
  endtask

  task automatic test_full_sweep();
    int  exp_a;
    bit  seen_done, busy_drop;
    exp_a     = 0;
    seen_done = 0;
    busy_drop = 0;
    m_ready_b = 1'b0;
    start_b   = 1'b1;
    for (int n = 1; n <= 60000; n++) begin
      tick();
      if (n == 1) start_b = 1'b0;
      if (done_b) begin
        seen_done = 1;
        break;
      end
      if (!busy_b) busy_drop = 1;
      m_ready_b = ($urandom_range(0, 3) != 0);
      if (m_valid_b && m_ready_b) begin
        total++;
        if ({m_addr_b, m_data_b, m_last_b} !== {14'(exp_a), big_pat(14'(exp_a)), (exp_a == 11999)}) begin
          bad++;
          $display("FAIL sweep_word got a=%0d d=%h l=%b exp a=%0d d=%h l=%b",
                   m_addr_b, m_data_b, m_last_b, exp_a, big_pat(14'(exp_a)), (exp_a == 11999));
          break;
        end
        exp_a++;
      end
    end
    total++;
    if ({seen_done, busy_b} !== 2'b10) begin
      bad++;
      $display("FAIL sweep_done got done=%b busy=%b exp done=1 busy=0", seen_done, busy_b);
    end
    total++;
    if (exp_a !== 12000) begin
      bad++;
      $display("FAIL sweep_count got=%0d exp=12000", exp_a);
    end
    total++;
    if (busy_drop !== 1'b0) begin
      bad++;
      $display("FAIL sweep_busy got drop=%b exp=0", busy_drop);
    end
  endtask

`ifdef DEBUG_MEM_READER_CHKSUM_EN
  task automatic test_chksum();
    m_ready4 = 1'b1;
    start4   = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) start4 = 1'b0;
      if (done4) break;
    end
    total++;
    if ({done4, chksum4} !== {1'b1, 32'hF}) begin
      bad++;
      $display("FAIL chk_done got done=%b sum=%h exp done=1 sum=f", done4, chksum4);
    end
    tick();
    tick();
    total++;
    if (chksum4 !== 32'hF) begin
      bad++;
      $display("FAIL chk_hold got=%h exp=f", chksum4);
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (chksum4 !== 32'h0) begin
      bad++;
      $display("FAIL chk_clear got=%h exp=0", chksum4);
    end
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done4) break;
    end
    total++;
    if ({done4, chksum4} !== {1'b1, 32'hF}) begin
      bad++;
      $display("FAIL chk_second got done=%b sum=%h exp done=1 sum=f", done4, chksum4);
    end
  endtask
`endif

  initial begin
    rstn      = 1'b0;
    start8    = 1'b0;
    m_ready8  = 1'b0;
    start_b   = 1'b0;
    m_ready_b = 1'b0;
`ifdef DEBUG_MEM_READER_CHKSUM_EN
    start4    = 1'b0;
    m_ready4  = 1'b0;
`endif
    test_reset();
    rstn = 1'b1;
    tick();
    test_basic();
    tick();
    test_backpressure();
    tick();
    test_start_ignored();
    tick();
    test_reset_mid();
    tick();
    test_back_to_back();
    repeat (3) tick();
    test_full_sweep();
`ifdef DEBUG_MEM_READER_CHKSUM_EN
    tick();
    test_chksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
